// File: rtl/cam_cfg_pkg.sv
// Shared types and table-entry encodings for the camera configuration sequencer.
package cam_cfg_pkg;

  localparam logic [15:0] CFG_END  = 16'hFFFF;
  localparam logic [15:0] CFG_WAIT = 16'hFFF0;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    WAIT_DONE,
    RELEASE,
    PAUSE,
    FINISH
  } seq_state_e;

endpackage

// File: rtl/cam_cfg_sequencer_if.sv
// Request/ready handshake between the sequencer (master) and the I2C register writer (slave).
interface cam_cfg_sequencer_if;

  logic        start_en_o;
  logic [7:0]  i2c_addr_o;
  logic [7:0]  i2c_data_o;
  logic [31:0] delay_o;
  logic        ready_i;

  modport master (output start_en_o, i2c_addr_o, i2c_data_o, delay_o, input ready_i);
  modport slave  (input start_en_o, i2c_addr_o, i2c_data_o, delay_o, output ready_i);

endinterface

// File: rtl/cam_cfg_rom.sv
// Combinational register table; ROM_SEL picks the image, anything unlisted reads as END.
module cam_cfg_rom
  import cam_cfg_pkg::*;
#(
  parameter int unsigned ROM_SEL = 0
) (
  input  logic [7:0]  idx,
  output logic [15:0] entry
);

  // NOTE: pure case decode with no storage, so there is nothing here to reset.
  always_comb begin
    entry = CFG_END;
    case (ROM_SEL)
      1: begin
        case (idx)
          8'd0:    entry = CFG_WAIT;
          8'd1:    entry = 16'h1280;
          8'd2:    entry = 16'h1101;
          default: entry = CFG_END;
        endcase
      end
      2: entry = {idx, ~idx};
      default: begin
        case (idx)
          8'd0:    entry = 16'h1280;
          8'd1:    entry = CFG_WAIT;
          8'd2:    entry = 16'h1101;
          8'd3:    entry = 16'h3A04;
          8'd4:    entry = 16'h1200;
          8'd5:    entry = 16'h8C00;
          8'd6:    entry = 16'h0400;
          8'd7:    entry = 16'h4010;
          default: entry = CFG_END;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/cam_cfg_sequencer.sv
// Walks the register table, handing each {addr,data} pair to the I2C writer with
// ack timeout, WAIT pauses and sticky done/error status.
module cam_cfg_sequencer
  import cam_cfg_pkg::*;
#(
  parameter logic [31:0] DELAY_CYCLES = 32'd250,
  parameter logic [31:0] WAIT_CYCLES  = 32'd1_000_000,
  parameter int unsigned ACK_TIMEOUT  = 16,
  parameter int unsigned ROM_SEL      = 0
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                cfg_start_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                error_o,
  output logic [7:0]          entry_idx_o,
  cam_cfg_sequencer_if.master i2c
);

  localparam int TW = $clog2(ACK_TIMEOUT) + 1;
  localparam logic [TW-1:0] TO_LAST = TW'(ACK_TIMEOUT - 1);

  seq_state_e    state, state_d;
  logic [31:0]   pause_cnt, pause_cnt_d;
  logic [TW-1:0] to_cnt, to_cnt_d;
  logic [7:0]    idx_d, addr_d, data_d;
  logic          busy_d, done_d, error_d;
  logic          advance;
  logic [15:0]   entry;

  cam_cfg_rom #(.ROM_SEL(ROM_SEL)) u_rom (
    .idx   (entry_idx_o),
    .entry (entry)
  );

  assign i2c.delay_o    = DELAY_CYCLES;
  // Decoded from the state register so an asserted resetn drops the request at once.
  assign i2c.start_en_o = (state == ISSUE) || (state == WAIT_DONE);

  // NOTE: every next-value gets its current value first, so no path leaves one unassigned (no latches).
  always_comb begin
    state_d     = state;
    pause_cnt_d = pause_cnt;
    to_cnt_d    = to_cnt;
    idx_d       = entry_idx_o;
    addr_d      = i2c.i2c_addr_o;
    data_d      = i2c.i2c_data_o;
    busy_d      = busy_o;
    done_d      = done_o;
    error_d     = error_o;
    advance     = 1'b0;

    case (state)
      IDLE: if (cfg_start_i) begin
        idx_d   = 8'd0;
        done_d  = 1'b0;
        error_d = 1'b0;
        busy_d  = 1'b1;
        state_d = FETCH;
      end
      FETCH: begin
        if (entry == CFG_END) begin
          state_d = FINISH;
        end else if (entry == CFG_WAIT) begin
          pause_cnt_d = WAIT_CYCLES;
          state_d     = PAUSE;
        end else begin
          addr_d   = entry[15:8];
          data_d   = entry[7:0];
          to_cnt_d = '0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (!i2c.ready_i) begin
          state_d = WAIT_DONE;
        end else if (to_cnt == TO_LAST) begin
          error_d = 1'b1;
          state_d = FINISH;
        end else begin
          to_cnt_d = to_cnt + 1'b1;
        end
      end
      WAIT_DONE: if (i2c.ready_i) state_d = RELEASE;
      RELEASE:   advance = 1'b1;
      PAUSE: begin
        if (pause_cnt == 32'd0) advance = 1'b1;
        else pause_cnt_d = pause_cnt - 32'd1;
      end
      FINISH: begin
        busy_d  = 1'b0;
        done_d  = !error_o;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Index 255 is the last entry; finishing here avoids wrapping back to 0.
    if (advance) begin
      if (entry_idx_o == 8'hFF) begin
        state_d = FINISH;
      end else begin
        idx_d   = entry_idx_o + 8'd1;
        state_d = FETCH;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments; the comb block above uses blocking.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= IDLE;
      pause_cnt      <= 32'd0;
      to_cnt         <= '0;
      entry_idx_o    <= 8'd0;
      i2c.i2c_addr_o <= 8'd0;
      i2c.i2c_data_o <= 8'd0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      error_o        <= 1'b0;
    end else begin
      state          <= state_d;
      pause_cnt      <= pause_cnt_d;
      to_cnt         <= to_cnt_d;
      entry_idx_o    <= idx_d;
      i2c.i2c_addr_o <= addr_d;
      i2c.i2c_data_o <= data_d;
      busy_o         <= busy_d;
      done_o         <= done_d;
      error_o        <= error_d;
    end
  end

endmodule

// File: tb/tb_cam_cfg_sequencer.sv
// Scoreboard bench: two sequencers (short table with WAIT, full 256-entry table)
// driven by randomized I2C writer models and checked against a table-walk model.
module tb_cam_cfg_sequencer;
  import cam_cfg_pkg::*;

  localparam int ACK_TO = 16;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [1:0]  cfg_start = '0;
  logic [1:0]  busy, done, error, start_en;
  logic [1:0]  deaf = '0;
  logic [7:0]  idx [2];
  logic [15:0] exp_q [2][$];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Table images as the walk model sees them.
  function automatic logic [15:0] tbl(input int sel, input int i);
    logic [7:0] b;
    b = i[7:0];
    if (sel == 1) begin
      case (i)
        0: return CFG_WAIT;
        1: return 16'h1280;
        2: return 16'h1101;
        default: return CFG_END;
      endcase
    end
    return {b, ~b};
  endfunction

  function automatic int model_end_idx(input int sel);
    for (int i = 0; i < 256; i++) if (tbl(sel, i) == CFG_END) return i;
    return 255;
  endfunction

  task automatic push_model(input int g);
    logic [15:0] e;
    for (int i = 0; i < 256; i++) begin
      e = tbl(g + 1, i);
      if (e == CFG_END) break;
      if (e != CFG_WAIT) exp_q[g].push_back(e);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    cam_cfg_sequencer_if bus ();

    cam_cfg_sequencer #(
      .DELAY_CYCLES (32'd250),
      .WAIT_CYCLES  ((g == 0) ? 32'd100 : 32'd3),
      .ACK_TIMEOUT  (ACK_TO),
      .ROM_SEL      (g + 1)
    ) u_dut (
      .clk         (clk),
      .resetn      (resetn),
      .cfg_start_i (cfg_start[g]),
      .busy_o      (busy[g]),
      .done_o      (done[g]),
      .error_o     (error[g]),
      .entry_idx_o (idx[g]),
      .i2c         (bus.master)
    );

    assign start_en[g] = bus.start_en_o;

    // I2C writer model: random accept latency and random transfer length.
    int phase = 0;
    int lat = 0;
    int hold = 0;
    initial bus.ready_i = 1'b1;
    always @(negedge clk) begin
      if (!resetn) begin
        bus.ready_i = 1'b1;
        phase = 0;
      end else begin
        case (phase)
          0: if (bus.start_en_o && !deaf[g]) begin
            lat = $urandom_range(0, 3);
            phase = 1;
          end
          1: if (lat == 0) begin
            bus.ready_i = 1'b0;
            hold = $urandom_range(1, 4);
            phase = 2;
          end else lat--;
          2: if (hold == 0) begin
            bus.ready_i = 1'b1;
            phase = 3;
          end else hold--;
          default: if (!bus.start_en_o) phase = 0;
        endcase
      end
    end

    // Monitor: compare each request against the scoreboard, then check it held steady.
    logic        prev_en = 1'b0;
    logic [15:0] cur = '0;
    always @(negedge clk) begin
      if (!resetn) begin
        prev_en = 1'b0;
      end else begin
        if (bus.start_en_o && !prev_en) begin
          cur = {bus.i2c_addr_o, bus.i2c_data_o};
          check($sformatf("txn_expected_u%0d", g), 32'(exp_q[g].size() != 0), 32'd1);
          if (exp_q[g].size() != 0)
            check($sformatf("txn_addr_data_u%0d", g), 32'(cur), 32'(exp_q[g].pop_front()));
        end else if (!bus.start_en_o && prev_en) begin
          check($sformatf("addr_data_stable_u%0d", g),
                32'({bus.i2c_addr_o, bus.i2c_data_o}), 32'(cur));
        end
        prev_en = bus.start_en_o;
      end
    end
  end

  // Called at a negedge; leaves the bench one cycle later with the walk accepted.
  task automatic start_walk(input int g);
    cfg_start[g] = 1'b1;
    @(negedge clk);
    cfg_start[g] = 1'b0;
    check("busy_after_start", 32'(busy[g]), 32'd1);
    check("done_cleared", 32'(done[g]), 32'd0);
    check("error_cleared", 32'(error[g]), 32'd0);
    check("idx_cleared", 32'(idx[g]), 32'd0);
  endtask

  // Waits for busy to fall; optionally pokes cfg_start while busy (must be ignored).
  task automatic wait_idle(input int g, input int budget, input bit poke);
    int n;
    n = 0;
    while (busy[g] && n < budget) begin
      if (poke && $urandom_range(0, 31) == 0) cfg_start[g] = 1'b1;
      @(negedge clk);
      cfg_start[g] = 1'b0;
      n++;
    end
    check("walk_finished_in_budget", 32'(n < budget), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int hi;

    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check("rst_busy", 32'(busy[g]), 32'd0);
      check("rst_done", 32'(done[g]), 32'd0);
      check("rst_error", 32'(error[g]), 32'd0);
      check("rst_idx", 32'(idx[g]), 32'd0);
      check("rst_start_en", 32'(start_en[g]), 32'd0);
    end
    check("rst_addr", 32'(g_dut[0].bus.i2c_addr_o), 32'd0);
    check("rst_data", 32'(g_dut[0].bus.i2c_data_o), 32'd0);
    check("delay_const", g_dut[0].bus.delay_o, 32'd250);
    resetn = 1'b1;
    @(negedge clk);

    // WAIT entry first: request rises WAIT_CYCLES+3 cycles after the start edge.
    push_model(0);
    start_walk(0);
    n = 0;
    while (!start_en[0] && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("wait_to_first_request", n, 32'd103);
    wait_idle(0, 400, 1'b1);
    check("walk0_done", 32'(done[0]), 32'd1);
    check("walk0_error", 32'(error[0]), 32'd0);
    check("walk0_end_idx", 32'(idx[0]), 32'(model_end_idx(1)));
    check("walk0_all_txns", exp_q[0].size(), 32'd0);

    // Writer never acknowledges: timeout after ACK_TO request cycles.
    deaf[0] = 1'b1;
    push_model(0);
    while (exp_q[0].size() > 1) void'(exp_q[0].pop_back());
    start_walk(0);
    n = 0;
    while (!start_en[0] && n < 500) begin
      @(negedge clk);
      n++;
    end
    hi = 0;
    while (start_en[0] && hi < 100) begin
      hi++;
      @(negedge clk);
    end
    check("timeout_issue_cycles", hi, ACK_TO);
    check("timeout_error_set", 32'(error[0]), 32'd1);
    wait_idle(0, 10, 1'b0);
    check("timeout_done_clear", 32'(done[0]), 32'd0);
    check("timeout_error_sticky", 32'(error[0]), 32'd1);
    check("timeout_start_en_low", 32'(start_en[0]), 32'd0);
    check("timeout_fsm_idle", 32'(g_dut[0].u_dut.state), 32'(IDLE));
    check("timeout_txns", exp_q[0].size(), 32'd0);
    deaf[0] = 1'b0;
    @(negedge clk);

    // Reset lands in WAIT_DONE of the second transaction.
    push_model(0);
    start_walk(0);
    n = 0;
    while (!(g_dut[0].u_dut.state == WAIT_DONE && idx[0] == 8'd2) && n < 600) begin
      @(negedge clk);
      n++;
    end
    check("reached_wait_done", 32'(n < 600), 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("async_rst_start_en", 32'(start_en[0]), 32'd0);
    check("async_rst_busy", 32'(busy[0]), 32'd0);
    check("async_rst_idx", 32'(idx[0]), 32'd0);
    exp_q[0].delete();
    repeat (2) @(negedge clk);
    #2 resetn = 1'b1;
    @(negedge clk);
    check("no_resume_after_rst", 32'(busy[0]), 32'd0);

    // Fresh start after reset walks from entry 0 again.
    push_model(0);
    start_walk(0);
    wait_idle(0, 600, 1'b1);
    check("restart_done", 32'(done[0]), 32'd1);
    check("restart_all_txns", exp_q[0].size(), 32'd0);

    // Full table: 256 transactions then finish at index 255 without wrapping.
    push_model(1);
    start_walk(1);
    wait_idle(1, 20000, 1'b1);
    check("full_done", 32'(done[1]), 32'd1);
    check("full_error", 32'(error[1]), 32'd0);
    check("full_end_idx", 32'(idx[1]), 32'(model_end_idx(2)));
    check("full_all_txns", exp_q[1].size(), 32'd0);
    repeat (3) @(negedge clk);
    check("full_stays_idle", 32'(busy[1]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
